vote_persist: RTL and testbench
===============================

Name: vote_persist

Overview:
- Parametrised successor to the fixed 4-input vote gates.
- Samples an N-bit vote vector every clock and population-counts it.
- Evaluates a programmable vote rule: threshold, exact-count, or required-members-plus-threshold.
- Asserts a registered, debounced vote output only after the rule holds for HOLD consecutive samples; releases it symmetrically.
- Sits between raw sensor/select inputs and downstream control logic that needs glitch-free decisions.

Parameters:
- N, 4, number of vote inputs (≥2).
- CW, $clog2(N+1), width of counts and threshold.
- HOLD, 3, consecutive matching (or non-matching) samples required to change vote (≥1).
- HW, $clog2(HOLD+1), persistence counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_bits  in  N  raw vote inputs; no synchroniser inside the block.
- threshold  in  CW  programmable count threshold.
- mode  in  2  0 = at-least, 1 = exact, 2 = masked, 3 = reserved (behaves as 0).
- req_mask  in  N  members that must all be set (used in mode 2 only).
- vote  out  1  registered debounced decision.
- vote_rise  out  1  one-cycle pulse on vote 0→1.
- vote_fall  out  1  one-cycle pulse on vote 1→0.
- pop_count  out  CW  popcount of the sampled vector s_bits.

Behaviour:
- Reset (async, rst_n=0): s_bits=0, state=IDLE, cnt=0, vote=0, vote_rise=0, vote_fall=0, pop_count=0. Release is taken at the next clk edge. Reset mid-ARM/REL discards partial counts.
- Every edge: s_bits <= in_bits. pop_count = popcount(s_bits), which is exact and cannot overflow because CW holds N.
- Combinational match from s_bits:
  - mode 0/3: pop_count ≥ threshold.
  - mode 1: pop_count == threshold.
  - mode 2: ((s_bits & req_mask) == req_mask) AND pop_count ≥ threshold.
- threshold/mode/req_mask are quasi-static. A change takes effect on match immediately and does not reset the FSM.
- FSM states: IDLE (vote=0), ARM (vote=0), ACTIVE (vote=1), REL (vote=1). All transitions occur at clk edges:
  - IDLE: match → ARM, cnt=1; if HOLD==1 → ACTIVE instead.
  - ARM: !match → IDLE, cnt=0. match and cnt==HOLD-1 → ACTIVE, cnt=0. Otherwise cnt+1.
  - ACTIVE: !match → REL, cnt=1; if HOLD==1 → IDLE instead.
  - REL: match → ACTIVE, cnt=0. !match and cnt==HOLD-1 → IDLE, cnt=0. Otherwise cnt+1.
- Latency: inputs applied before edge k are sampled at k, and vote changes at edge k+HOLD. Any single contrary sample restarts the count.
- vote is a flop updated on the same edge as the state.
- vote_rise is high for exactly the one cycle after an ARM/IDLE→ACTIVE edge.
- vote_fall is high for exactly the one cycle after a REL/ACTIVE→IDLE edge.
- REL→ACTIVE produces no pulses. vote_rise and vote_fall are never high together.
- Boundaries:
  - threshold=0 in mode 0: match is always true.
  - threshold>N in modes 0/2: match is never true.
  - req_mask=0 in mode 2: reduces to mode 0.
  - cnt never exceeds HOLD-1.

Test Plan (N=4, HOLD=3):
1. Reset: rst_n=0 asserted mid-clock while in ACTIVE → vote=0 and all pulses 0 immediately, with no clock needed. Release, then in_bits=0 held → vote stays 0.
2. Mode 0, threshold=3: in_bits 0000→1011 before edge k → pop_count=3 after k; vote=1 after edge k+3; vote_rise=1 for one cycle only.
3. Debounce: mode 0, threshold=3, in_bits=1110 for 2 samples, then 0110 for 1, then 1110 steady → vote rises only 3 edges after the final 1110 sample. Dropping to 0001 for 3 samples → vote_fall pulse, vote=0.
4. Mode 2, req_mask=0011, threshold=3 (≡ A&B&(C|D) with A,B at bits 0,1):
   - 0111 → vote=1.
   - 1101 → no vote (bit1 missing).
   - 1011 → vote=1.
   - Repeat with req_mask=1100: 1110 → 1, 0111 → 0.
5. Mode 1, threshold=2: 0011 → vote=1. Then 0111 for exactly 2 samples, back to 0011 → vote stays 1 with no pulses (REL→ACTIVE).
6. Edges: threshold=0 mode 0 → vote=1 after 3 edges with in_bits=0. threshold=5 → never. Mode 3 matches mode 0 results for scenario 2.

Source files
------------

// File: rtl/vote_persist.sv
// Debounced N-input vote: popcounts a registered sample of in_bits, evaluates a
// programmable rule and only moves the vote after HOLD consecutive agreeing samples.
module vote_persist #(
  parameter int N    = 4,
  parameter int CW   = $clog2(N + 1),
  parameter int HOLD = 3,
  parameter int HW   = $clog2(HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_bits,
  input  logic [CW-1:0] threshold,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  req_mask,
  output logic          vote,
  output logic          vote_rise,
  output logic          vote_fall,
  output logic [CW-1:0] pop_count
);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, REL} state_t;

  localparam logic [HW-1:0] CNT_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0] CNT_ONE  = HW'(1);

  state_t        state_reg, state_next;
  logic [HW-1:0] cnt_reg, cnt_next;
  logic [N-1:0]  s_bits_reg;
  logic          vote_reg, vote_next;
  logic          rise_reg, rise_next;
  logic          fall_reg, fall_next;
  logic [CW-1:0] pop_next;
  logic [N-1:0]  req_ok;
  logic          match;

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < N; i++) begin
      pop_next = pop_next + CW'(s_bits_reg[i]);
    end
  end

  // A member satisfies the mask check if it is either not required or present.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign req_ok[gi] = ~req_mask[gi] | s_bits_reg[gi];
    end
  endgenerate

  always_comb begin
    match = (pop_next >= threshold);
    case (mode)
      2'd1:    match = (pop_next == threshold);
      2'd2:    match = (&req_ok) && (pop_next >= threshold);
      default: match = (pop_next >= threshold);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (match) begin
          if (HOLD == 1) begin
            state_next = ACTIVE;
            cnt_next   = '0;
          end else begin
            state_next = ARM;
            cnt_next   = CNT_ONE;
          end
        end
      end
      ARM: begin
        if (!match) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ACTIVE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ACTIVE: begin
        if (!match) begin
          if (HOLD == 1) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            state_next = REL;
            cnt_next   = CNT_ONE;
          end
        end
      end
      REL: begin
        if (match) begin
          state_next = ACTIVE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // REL->ACTIVE keeps vote high, so it deliberately produces no pulse.
  always_comb begin
    vote_next = (state_next == ACTIVE) || (state_next == REL);
    rise_next = (state_next == ACTIVE) && ((state_reg == IDLE) || (state_reg == ARM));
    fall_next = (state_next == IDLE) && ((state_reg == ACTIVE) || (state_reg == REL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      s_bits_reg <= '0;
      vote_reg   <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      s_bits_reg <= in_bits;
      vote_reg   <= vote_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
    end
  end

  assign vote      = vote_reg;
  assign vote_rise = rise_reg;
  assign vote_fall = fall_reg;
  assign pop_count = pop_next;

endmodule

// File: tb/tb_vote_persist.sv
// Bench for vote_persist: directed scenarios plus random segments, all checked
// against a run-length reference model of the debounced vote.
module tb_vote_persist;

  localparam int N    = 4;
  localparam int CW   = 3;
  localparam int HOLD = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_bits;
  logic [CW-1:0] threshold;
  logic [1:0]    mode;
  logic [N-1:0]  req_mask;
  logic          vote, vote_rise, vote_fall;
  logic [CW-1:0] pop_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: last sample, current vote, run of contrary samples.
  logic [N-1:0] s_m;
  bit           vote_m, rise_m, fall_m;
  int           run_m;

  vote_persist #(.N(N), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bits   (in_bits),
    .threshold (threshold),
    .mode      (mode),
    .req_mask  (req_mask),
    .vote      (vote),
    .vote_rise (vote_rise),
    .vote_fall (vote_fall),
    .pop_count (pop_count)
  );

  always #5 clk = ~clk;

  function automatic bit ref_match(input logic [N-1:0] s);
    int pc;
    pc = $countones(s);
    case (mode)
      2'd1:    return pc == int'(threshold);
      2'd2:    return ((s & req_mask) == req_mask) && (pc >= int'(threshold));
      default: return pc >= int'(threshold);
    endcase
  endfunction

  task automatic model_reset();
    s_m = '0; vote_m = 0; rise_m = 0; fall_m = 0; run_m = 0;
  endtask

  // The vote flips once HOLD consecutive evaluated samples disagree with it.
  task automatic model_edge();
    bit m;
    m = ref_match(s_m);
    rise_m = 0;
    fall_m = 0;
    if (m != vote_m) run_m++;
    else run_m = 0;
    if (run_m == HOLD) begin
      vote_m = !vote_m;
      rise_m = vote_m;
      fall_m = !vote_m;
      run_m  = 0;
    end
    s_m = in_bits;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] b);
    in_bits = b;
    model_edge();
    @(posedge clk);
    #1;
    chk("vote", 32'(vote), 32'(vote_m));
    chk("vote_rise", 32'(vote_rise), 32'(rise_m));
    chk("vote_fall", 32'(vote_fall), 32'(fall_m));
    chk("pop_count", 32'(pop_count), 32'($countones(s_m)));
  endtask

  task automatic cfg(input logic [1:0] md, input logic [CW-1:0] th, input logic [N-1:0] mk);
    mode = md; threshold = th; req_mask = mk;
  endtask

  task automatic repeat_step(input logic [N-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  task automatic drain();
    cfg(2'd0, 3'd3, 4'b0000);
    repeat_step(4'b0000, HOLD + 2);
  endtask

  initial begin
    rst_n = 1'b0; in_bits = '0;
    cfg(2'd0, 3'd3, 4'b0000);
    model_reset();
    #12;
    chk("reset_vote", 32'(vote), 32'd0);
    chk("reset_pop", 32'(pop_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reach ACTIVE, then async reset mid-cycle
    cfg(2'd0, 3'd0, 4'b0000);
    repeat_step(4'b1111, 5);
    chk("pre_reset_active", 32'(vote), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_vote", 32'(vote), 32'd0);
    chk("async_rise", 32'(vote_rise), 32'd0);
    chk("async_fall", 32'(vote_fall), 32'd0);
    chk("async_pop", 32'(pop_count), 32'd0);
    #3 rst_n = 1'b1;
    cfg(2'd0, 3'd3, 4'b0000);
    repeat_step(4'b0000, 5);

    // 2: threshold 3, rise exactly HOLD edges after the sample edge
    step(4'b1011);
    chk("s2_pop", 32'(pop_count), 32'd3);
    repeat_step(4'b1011, 2);
    chk("s2_vote_early", 32'(vote), 32'd0);
    step(4'b1011);
    chk("s2_vote", 32'(vote), 32'd1);
    chk("s2_rise", 32'(vote_rise), 32'd1);
    step(4'b1011);
    chk("s2_rise_once", 32'(vote_rise), 32'd0);
    drain();

    // 3: a single contrary sample restarts the count
    repeat_step(4'b1110, 2);
    step(4'b0110);
    repeat_step(4'b1110, 3);
    chk("s3_not_yet", 32'(vote), 32'd0);
    step(4'b1110);
    chk("s3_vote", 32'(vote), 32'd1);
    repeat_step(4'b0001, 4);
    chk("s3_released", 32'(vote), 32'd0);

    // 4: masked mode
    cfg(2'd2, 3'd3, 4'b0011);
    repeat_step(4'b0111, 5); chk("s4_0111", 32'(vote), 32'd1);
    repeat_step(4'b1101, 5); chk("s4_1101", 32'(vote), 32'd0);
    repeat_step(4'b1011, 5); chk("s4_1011", 32'(vote), 32'd1);
    cfg(2'd2, 3'd3, 4'b1100);
    repeat_step(4'b1110, 5); chk("s4_1110", 32'(vote), 32'd1);
    repeat_step(4'b0111, 5); chk("s4_0111m", 32'(vote), 32'd0);

    // 5: exact mode, short contrary burst recovers without pulses
    cfg(2'd1, 3'd2, 4'b0000);
    repeat_step(4'b0011, 5); chk("s5_vote", 32'(vote), 32'd1);
    repeat_step(4'b0111, 2);
    repeat_step(4'b0011, 4); chk("s5_held", 32'(vote), 32'd1);

    // 6: boundaries
    drain();
    cfg(2'd0, 3'd0, 4'b0000);
    repeat_step(4'b0000, 4); chk("s6_thr0", 32'(vote), 32'd1);
    cfg(2'd0, 3'd5, 4'b0000);
    repeat_step(4'b1111, 6); chk("s6_thr5", 32'(vote), 32'd0);
    drain();
    cfg(2'd3, 3'd3, 4'b0000);
    repeat_step(4'b1011, 4); chk("s6_mode3", 32'(vote), 32'd1);
    drain();

    // Random segments: config changes mid-run without resetting the FSM
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 3) == 0)
        cfg(2'($urandom_range(0, 3)), 3'($urandom_range(0, 5)), 4'($urandom));
      repeat_step(4'($urandom), int'($urandom_range(1, 5)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
